// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } sw_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT      = 4'd9;
    localparam int         NUM_DIGITS_DEFAULT = 8;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter: one 0..9 counter per digit, carry rippling through all digits in one cycle.
module bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int N = NUM_DIGITS_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           inc_i,
    output logic [4*N-1:0] count_o,
    output logic           wrap_o
);

    logic [N:0] carry;

    assign carry[0] = inc_i;

    for (genvar g = 0; g < N; g++) begin : g_digit
        logic [3:0] digit_q;
        logic [3:0] digit_d;

        // A digit at 9 (or anything larger) rolls to 0 and passes the carry on.
        always_comb begin
            digit_d = digit_q;
            if (clear_i) begin
                digit_d = 4'd0;
            end else if (carry[g]) begin
                digit_d = (digit_q >= BCD_MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
            end
        end

        assign carry[g+1] = carry[g] && (digit_q >= BCD_MAX_DIGIT);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                digit_q <= 4'd0;
            end else begin
                digit_q <= digit_d;
            end
        end

        assign count_o[4*g +: 4] = digit_q;
    end

    assign wrap_o = carry[N] && !clear_i;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/stop/lap/clear sequencing around a BCD time register with a lap snapshot.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    btn_start_stop_i,
    input  logic                    btn_lap_i,
    input  logic                    btn_clear_i,
    input  logic                    time_tick_i,
    output logic                    timer_start_o,
    output logic [4*NUM_DIGITS-1:0] display_value_o,
    output logic                    lap_active_o,
    output logic                    overflow_o
);

    localparam int W = 4 * NUM_DIGITS;

    sw_state_t      state_q, state_d;
    logic           clear_cnt;
    logic           take_snap;
    logic           inc_cnt;
    logic           wrap;
    logic [W-1:0]   count;
    logic [W-1:0]   snapshot_q, snapshot_d;
    logic [W-1:0]   display_q, display_d;
    logic           timer_start_q, timer_start_d;
    logic           lap_active_q, lap_active_d;
    logic           overflow_q, overflow_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear outranks start/stop, which outranks lap; clear only acts when not running.
    always_comb begin
        state_d   = state_q;
        clear_cnt = 1'b0;
        take_snap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_clear_i) begin
                    clear_cnt = 1'b1;
                end else if (btn_start_stop_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (btn_start_stop_i) begin
                    state_d = STOP;
                end else if (btn_lap_i) begin
                    state_d   = LAP;
                    take_snap = 1'b1;
                end
            end
            LAP: begin
                if (btn_start_stop_i) begin
                    state_d = STOP;
                end else if (btn_lap_i) begin
                    state_d = RUN;
                end
            end
            STOP: begin
                if (btn_clear_i) begin
                    state_d   = IDLE;
                    clear_cnt = 1'b1;
                end else if (btn_start_stop_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inc_cnt = time_tick_i && ((state_q == RUN) || (state_q == LAP));

    bcd_counter #(
        .N(NUM_DIGITS)
    ) u_live_count (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_cnt),
        .inc_i   (inc_cnt),
        .count_o (count),
        .wrap_o  (wrap)
    );

    // The snapshot captures the count before any same-cycle tick lands.
    always_comb begin
        snapshot_d    = take_snap ? count : snapshot_q;
        display_d     = (state_q == LAP) ? snapshot_q : count;
        timer_start_d = (state_d == RUN) || (state_d == LAP);
        lap_active_d  = (state_d == LAP);
        overflow_d    = clear_cnt ? 1'b0 : (overflow_q || wrap);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snapshot_q    <= '0;
            display_q     <= '0;
            timer_start_q <= 1'b0;
            lap_active_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            snapshot_q    <= snapshot_d;
            display_q     <= display_d;
            timer_start_q <= timer_start_d;
            lap_active_q  <= lap_active_d;
            overflow_q    <= overflow_d;
        end
    end

    assign timer_start_o   = timer_start_q;
    assign display_value_o = display_q;
    assign lap_active_o    = lap_active_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an 8-digit and a 3-digit instance share all stimulus.
module tb_stopwatch_ctrl;

    logic        clock = 1'b0;
    logic        resetN;
    logic        btnStartStop, btnLap, btnClear, timeTick;
    logic        timerStartA, lapActiveA, overflowA;
    logic [31:0] displayA;
    logic        timerStartB, lapActiveB, overflowB;
    logic [11:0] displayB;

    always #5 clock = ~clock;

    stopwatch_ctrl #(.NUM_DIGITS(8)) dutMain (
        .clk_i            (clock),
        .rst_ni           (resetN),
        .btn_start_stop_i (btnStartStop),
        .btn_lap_i        (btnLap),
        .btn_clear_i      (btnClear),
        .time_tick_i      (timeTick),
        .timer_start_o    (timerStartA),
        .display_value_o  (displayA),
        .lap_active_o     (lapActiveA),
        .overflow_o       (overflowA)
    );

    stopwatch_ctrl #(.NUM_DIGITS(3)) dutSmall (
        .clk_i            (clock),
        .rst_ni           (resetN),
        .btn_start_stop_i (btnStartStop),
        .btn_lap_i        (btnLap),
        .btn_clear_i      (btnClear),
        .time_tick_i      (timeTick),
        .timer_start_o    (timerStartB),
        .display_value_o  (displayB),
        .lap_active_o     (lapActiveB),
        .overflow_o       (overflowB)
    );

    typedef struct {
        logic [31:0] dispA;
        logic        ovfA;
        logic [31:0] dispB;
        logic        ovfB;
        logic        ts;
        logic        lap;
    } expect_t;

    expect_t sbQueue[$];
    int      assertCount = 0;
    int      failCount   = 0;

    // Reference model in plain decimal integers; 0=IDLE 1=RUN 2=LAP 3=STOP.
    int mState;
    int mCount[2];
    int mSnap[2];
    int mDisp[2];
    bit mOvf[2];
    bit mTs, mLap;
    int modulus[2] = '{100000000, 1000};

    function automatic logic [31:0] toBcd(input int value);
        logic [31:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] validBcd(input logic [31:0] value);
        logic [31:0] ok;
        ok = 32'd1;
        for (int i = 0; i < 8; i++) begin
            if (value[4*i +: 4] > 4'd9) ok = 32'd0;
        end
        return ok;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mTs    = 1'b0;
        mLap   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mCount[d] = 0;
            mSnap[d]  = 0;
            mDisp[d]  = 0;
            mOvf[d]   = 1'b0;
        end
    endtask

    task automatic modelStep(input bit ss, input bit lap, input bit clr, input bit tick);
        int ns;
        bit clrCnt, snap, counting;
        ns       = mState;
        clrCnt   = 1'b0;
        snap     = 1'b0;
        counting = tick && (mState == 1 || mState == 2);
        case (mState)
            0: if (clr) clrCnt = 1'b1; else if (ss) ns = 1;
            1: if (ss) ns = 3; else if (lap) begin ns = 2; snap = 1'b1; end
            2: if (ss) ns = 3; else if (lap) ns = 1;
            default: if (clr) begin ns = 0; clrCnt = 1'b1; end else if (ss) ns = 1;
        endcase
        for (int d = 0; d < 2; d++) begin
            mDisp[d] = (mState == 2) ? mSnap[d] : mCount[d];
            if (snap) mSnap[d] = mCount[d];
            if (clrCnt) begin
                mCount[d] = 0;
                mOvf[d]   = 1'b0;
            end else if (counting) begin
                if (mCount[d] + 1 == modulus[d]) begin
                    mCount[d] = 0;
                    mOvf[d]   = 1'b1;
                end else begin
                    mCount[d] = mCount[d] + 1;
                end
            end
        end
        mState = ns;
        mTs    = (ns == 1) || (ns == 2);
        mLap   = (ns == 2);
    endtask

    task automatic compareFront();
        expect_t e;
        e = sbQueue.pop_front();
        checkOutput("displayMain", displayA, e.dispA);
        checkOutput("overflowMain", 32'(overflowA), 32'(e.ovfA));
        checkOutput("displaySmall", 32'(displayB), e.dispB);
        checkOutput("overflowSmall", 32'(overflowB), 32'(e.ovfB));
        checkOutput("timerStart", 32'(timerStartA), 32'(e.ts));
        checkOutput("lapActive", 32'(lapActiveA), 32'(e.lap));
        checkOutput("timerStartSmall", 32'(timerStartB), 32'(e.ts));
        checkOutput("nibbleValid", validBcd(displayA), 32'd1);
    endtask

    // Drives one cycle of inputs, pushes the model's expectation, then compares after the edge.
    task automatic applyStimulus(input bit ss, input bit lap, input bit clr, input bit tick);
        expect_t e;
        btnStartStop = ss;
        btnLap       = lap;
        btnClear     = clr;
        timeTick     = tick;
        modelStep(ss, lap, clr, tick);
        e.dispA = toBcd(mDisp[0]);
        e.ovfA  = mOvf[0];
        e.dispB = toBcd(mDisp[1]);
        e.ovfB  = mOvf[1];
        e.ts    = mTs;
        e.lap   = mLap;
        sbQueue.push_back(e);
        @(posedge clock);
        #1;
        btnStartStop = 1'b0;
        btnLap       = 1'b0;
        btnClear     = 1'b0;
        timeTick     = 1'b0;
        compareFront();
    endtask

    task automatic ticks(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Display"}, displayA, 32'h0);
        checkOutput({tag, "DisplaySmall"}, 32'(displayB), 32'h0);
        checkOutput({tag, "TimerStart"}, 32'(timerStartA), 32'h0);
        checkOutput({tag, "LapActive"}, 32'(lapActiveA), 32'h0);
        checkOutput({tag, "Overflow"}, 32'(overflowA), 32'h0);
        checkOutput({tag, "OverflowSmall"}, 32'(overflowB), 32'h0);
    endtask

    initial begin
        resetN       = 1'b0;
        btnStartStop = 1'b0;
        btnLap       = 1'b0;
        btnClear     = 1'b0;
        timeTick     = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset");
        resetN = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(12);
        idle();
        checkOutput("twelveTicks", displayA, 32'h00000012);
        checkOutput("runTimerStart", 32'(timerStartA), 32'd1);

        ticks(87);
        idle();
        checkOutput("at99", displayA, 32'h00000099);
        ticks(1);
        idle();
        checkOutput("carryTo100", displayA, 32'h00000100);

        ticks(157);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            checkOutput("lapFrozen", displayA, 32'h00000257);
            checkOutput("lapFlag", 32'(lapActiveA), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        checkOutput("lapRelease", displayA, 32'h00000262);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        checkOutput("stopWithTick", displayA, 32'h00000041);
        checkOutput("stopTimerStart", 32'(timerStartA), 32'd0);
        ticks(3);
        checkOutput("stopIgnoresTicks", displayA, 32'h00000041);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(500);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        checkOutput("clearInRunIgnored", displayA, 32'h00000500);
        checkOutput("clearInRunTimer", 32'(timerStartA), 32'd1);
        ticks(734);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        checkOutput("stopAt1234", displayA, 32'h00001234);
        checkOutput("smallWrapped", 32'(displayB), 32'h00000234);
        checkOutput("smallOverflow", 32'(overflowB), 32'd1);
        checkOutput("mainNoOverflow", 32'(overflowA), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        checkOutput("clearBeatsStart", displayA, 32'h00000000);
        checkOutput("clearTimerStart", 32'(timerStartA), 32'd0);
        checkOutput("clearOverflow", 32'(overflowB), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        #3;
        resetN = 1'b0;
        #1;
        checkAllZero("asyncReset");
        sbQueue.delete();
        modelReset();
        @(posedge clock);
        #1;
        checkAllZero("heldReset");
        resetN = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        idle();
        checkOutput("afterReset", displayA, 32'h00000002);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
